// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for id_ex_stage.
// Holds the ALU opcode package and the valid/ready handshake interface.
package id_ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  import id_ex_pkg::*;

  logic                             id_valid;
  logic                             id_ready;
  logic [DATA_WIDTH-1:0]            id_pc;
  logic [DATA_WIDTH-1:0]            id_rs1_data;
  logic [DATA_WIDTH-1:0]            id_rs2_data;
  logic [REG_ADDR_WIDTH-1:0]        id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0]        id_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0]        id_rd_addr;
  logic [DATA_WIDTH-1:0]            id_imm;
  alu_op_t                          id_alu_op;
  logic [1:0]                       id_a_sel;
  logic                             id_b_sel;
  logic                             id_reg_wr;

  logic                             ex_valid;
  logic                             ex_ready;
  logic signed [DATA_WIDTH-1:0]     ex_opr_a;
  logic signed [DATA_WIDTH-1:0]     ex_opr_b;
  alu_op_t                          ex_alu_op;
  logic [DATA_WIDTH-1:0]            ex_store_data;
  logic [DATA_WIDTH-1:0]            ex_pc;
  logic [REG_ADDR_WIDTH-1:0]        ex_rd_addr;
  logic                             ex_reg_wr;

  modport master (
    output id_valid, id_pc,
    output id_rs1_data, id_rs2_data,
    output id_rs1_addr, id_rs2_addr,
    output id_rd_addr, id_imm,
    output id_alu_op, id_a_sel,
    output id_b_sel, id_reg_wr,
    input  id_ready,
    output ex_ready,
    input  ex_valid, ex_opr_a,
    input  ex_opr_b, ex_alu_op,
    input  ex_store_data, ex_pc,
    input  ex_rd_addr, ex_reg_wr
  );

  modport slave (
    input  id_valid, id_pc,
    input  id_rs1_data, id_rs2_data,
    input  id_rs1_addr, id_rs2_addr,
    input  id_rd_addr, id_imm,
    input  id_alu_op, id_a_sel,
    input  id_b_sel, id_reg_wr,
    output id_ready,
    input  ex_ready,
    output ex_valid, ex_opr_a,
    output ex_opr_b, ex_alu_op,
    output ex_store_data, ex_pc,
    output ex_rd_addr, ex_reg_wr
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding.
// Single-entry buffer; stalled operands are refreshed from the bypass.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      mem_fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  input  logic                      wb_fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
  id_ex_stage_if.slave              bus
);
  import id_ex_pkg::*;

  logic                      vld_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [DATA_WIDTH-1:0]     rs1_q;
  logic [DATA_WIDTH-1:0]     rs2_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1a_q;
  logic [REG_ADDR_WIDTH-1:0] rs2a_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  alu_op_t                   op_q;
  logic [1:0]                asel_q;
  logic                      bsel_q;
  logic                      wr_q;

  logic                      load;
  logic                      stall;
  logic                      mem_hit1, mem_hit2;
  logic                      wb_hit1, wb_hit2;
  logic [DATA_WIDTH-1:0]     fwd1, fwd2;
  logic [DATA_WIDTH-1:0]     opr_a, opr_b;

  assign bus.id_ready = !vld_q || bus.ex_ready;
  assign load  = bus.id_valid && bus.id_ready && !flush;
  assign stall = vld_q && !bus.ex_ready;

  // x0 is hardwired zero, so it is never bypassed
  assign mem_hit1 = mem_fwd_en && (mem_fwd_rd == rs1a_q)
                    && (rs1a_q != '0);
  assign mem_hit2 = mem_fwd_en && (mem_fwd_rd == rs2a_q)
                    && (rs2a_q != '0);
  assign wb_hit1  = !mem_hit1 && wb_fwd_en
                    && (wb_fwd_rd == rs1a_q) && (rs1a_q != '0);
  assign wb_hit2  = !mem_hit2 && wb_fwd_en
                    && (wb_fwd_rd == rs2a_q) && (rs2a_q != '0);

  always_comb begin
    fwd1 = rs1_q;
    unique case (1'b1)
      mem_hit1: fwd1 = mem_fwd_data;
      wb_hit1:  fwd1 = wb_fwd_data;
      default:  fwd1 = rs1_q;
    endcase
  end

  always_comb begin
    fwd2 = rs2_q;
    unique case (1'b1)
      mem_hit2: fwd2 = mem_fwd_data;
      wb_hit2:  fwd2 = wb_fwd_data;
      default:  fwd2 = rs2_q;
    endcase
  end

  always_comb begin
    opr_a = '0;
    case (asel_q)
      2'd0:    opr_a = fwd1;
      2'd1:    opr_a = pc_q;
      default: opr_a = '0;
    endcase
  end

  assign opr_b = bsel_q ? imm_q : fwd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q <= 1'b1;
    end else if (bus.ex_ready) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      rs1a_q <= '0;
      rs2a_q <= '0;
      rd_q   <= '0;
      op_q   <= ALU_ADD;
      asel_q <= '0;
      bsel_q <= 1'b0;
      wr_q   <= 1'b0;
    end else if (load) begin
      pc_q   <= bus.id_pc;
      rs1_q  <= bus.id_rs1_data;
      rs2_q  <= bus.id_rs2_data;
      imm_q  <= bus.id_imm;
      rs1a_q <= bus.id_rs1_addr;
      rs2a_q <= bus.id_rs2_addr;
      rd_q   <= bus.id_rd_addr;
      op_q   <= bus.id_alu_op;
      asel_q <= bus.id_a_sel;
      bsel_q <= bus.id_b_sel;
      wr_q   <= bus.id_reg_wr;
    end else if (stall) begin
      // capture a producer that retires while we wait
      rs1_q <= fwd1;
      rs2_q <= fwd2;
    end
  end

  assign bus.ex_valid      = vld_q;
  assign bus.ex_opr_a      = opr_a;
  assign bus.ex_opr_b      = opr_b;
  assign bus.ex_alu_op     = op_q;
  assign bus.ex_store_data = fwd2;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd_addr    = rd_q;
  assign bus.ex_reg_wr     = wr_q && vld_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: transfers checked by a monitor,
// stall/forward/flush/reset behaviour checked directly.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mem_fwd_en = 1'b0;
  logic [4:0]  mem_fwd_rd = '0;
  logic [31:0] mem_fwd_data = '0;
  logic        wb_fwd_en = 1'b0;
  logic [4:0]  wb_fwd_rd = '0;
  logic [31:0] wb_fwd_data = '0;

  int tests = 0;
  int fails = 0;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .mem_fwd_en   (mem_fwd_en),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_en    (wb_fwd_en),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_data  (wb_fwd_data),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    alu_op_t     op;
    logic [1:0]  asel;
    logic        bsel, wr;
  } ins_t;

  typedef struct {
    logic [31:0] a, b, st, pc;
    logic [4:0]  rd;
    logic        wr;
    alu_op_t     op;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ex_valid && bus.ex_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got pc %h expected none",
                 bus.ex_pc);
      end else begin
        e = q.pop_front();
        chk("out_a", 32'(bus.ex_opr_a), e.a);
        chk("out_b", 32'(bus.ex_opr_b), e.b);
        chk("out_store", bus.ex_store_data, e.st);
        chk("out_pc", bus.ex_pc, e.pc);
        chk("out_rd", 32'(bus.ex_rd_addr), 32'(e.rd));
        chk("out_wr", 32'(bus.ex_reg_wr), 32'(e.wr));
        chk("out_op", 32'(bus.ex_alu_op), 32'(e.op));
      end
    end
  end

  task automatic drive(input ins_t i);
    bus.id_pc       = i.pc;
    bus.id_rs1_data = i.rs1d;
    bus.id_rs2_data = i.rs2d;
    bus.id_imm      = i.imm;
    bus.id_rs1_addr = i.rs1a;
    bus.id_rs2_addr = i.rs2a;
    bus.id_rd_addr  = i.rd;
    bus.id_alu_op   = i.op;
    bus.id_a_sel    = i.asel;
    bus.id_b_sel    = i.bsel;
    bus.id_reg_wr   = i.wr;
    bus.id_valid    = 1'b1;
  endtask

  task automatic send(input ins_t i);
    logic rdy;
    int n;
    n = 0;
    drive(i);
    do begin
      @(negedge clk);
      rdy = bus.id_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got id_ready 0 expected 1");
    end
    bus.id_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t i;
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    drive('{pc:0, rs1d:0, rs2d:0, imm:0, rs1a:0, rs2a:0,
            rd:0, op:ALU_ADD, asel:0, bsel:0, wr:0});
    bus.id_valid = 1'b0;

    #12;
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_a", 32'(bus.ex_opr_a), 0);
    chk("rst_b", 32'(bus.ex_opr_b), 0);
    chk("rst_store", bus.ex_store_data, 0);
    chk("rst_pc", bus.ex_pc, 0);
    chk("rst_rd", 32'(bus.ex_rd_addr), 0);
    chk("rst_wr", 32'(bus.ex_reg_wr), 0);
    chk("rst_op", 32'(bus.ex_alu_op), 32'(ALU_ADD));
    chk("rst_ready", 32'(bus.id_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // basic load
    i = '{pc:32'h100, rs1d:5, rs2d:9, imm:7, rs1a:1, rs2a:2,
          rd:1, op:ALU_ADD, asel:0, bsel:1, wr:1};
    q.push_back('{a:5, b:7, st:9, pc:32'h100, rd:1, wr:1,
                  op:ALU_ADD});
    send(i);
    @(negedge clk);
    chk("load_valid", 32'(bus.ex_valid), 1);
    chk("load_ready", 32'(bus.id_ready), 1);
    step(1);
    chk("drain_valid", 32'(bus.ex_valid), 0);

    // backpressure
    bus.ex_ready = 1'b0;
    i = '{pc:32'h200, rs1d:32'h60, rs2d:32'h70, imm:0, rs1a:6,
          rs2a:7, rd:2, op:ALU_ADD, asel:0, bsel:0, wr:1};
    q.push_back('{a:32'h60, b:32'h70, st:32'h70, pc:32'h200,
                  rd:2, wr:1, op:ALU_ADD});
    send(i);
    i = '{pc:32'h300, rs1d:32'h80, rs2d:32'h90, imm:32'h10,
          rs1a:8, rs2a:9, rd:3, op:ALU_SUB, asel:1, bsel:1, wr:0};
    q.push_back('{a:32'h300, b:32'h10, st:32'h90, pc:32'h300,
                  rd:3, wr:0, op:ALU_SUB});
    drive(i);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.id_ready), 0);
      chk("bp_a", 32'(bus.ex_opr_a), 32'h60);
      chk("bp_pc", bus.ex_pc, 32'h200);
      step(1);
    end
    bus.ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.id_ready), 1);
    step(1);
    bus.id_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_pc", bus.ex_pc, 32'h300);
    step(1);

    // forwarding priority, then refresh keeps the WB value
    bus.ex_ready = 1'b0;
    i = '{pc:32'h400, rs1d:32'h11, rs2d:32'h55, imm:0, rs1a:3,
          rs2a:5, rd:4, op:ALU_XOR, asel:0, bsel:0, wr:1};
    q.push_back('{a:32'h33, b:32'h55, st:32'h55, pc:32'h400,
                  rd:4, wr:1, op:ALU_XOR});
    send(i);
    mem_fwd_en = 1'b1; mem_fwd_rd = 3; mem_fwd_data = 32'h22;
    wb_fwd_en = 1'b1;  wb_fwd_rd = 3;  wb_fwd_data = 32'h33;
    @(negedge clk);
    chk("fwd_mem_prio", 32'(bus.ex_opr_a), 32'h22);
    step(1);
    mem_fwd_en = 1'b0;
    @(negedge clk);
    chk("fwd_wb", 32'(bus.ex_opr_a), 32'h33);
    step(1);
    wb_fwd_en = 1'b0;
    @(negedge clk);
    chk("fwd_refreshed", 32'(bus.ex_opr_a), 32'h33);
    step(1);
    bus.ex_ready = 1'b1;
    step(1);

    // x0 never forwarded
    bus.ex_ready = 1'b0;
    i = '{pc:32'h500, rs1d:32'h44, rs2d:32'h66, imm:0, rs1a:0,
          rs2a:0, rd:5, op:ALU_OR, asel:0, bsel:0, wr:1};
    q.push_back('{a:32'h44, b:32'h66, st:32'h66, pc:32'h500,
                  rd:5, wr:1, op:ALU_OR});
    send(i);
    mem_fwd_en = 1'b1; mem_fwd_rd = 0; mem_fwd_data = 32'h22;
    wb_fwd_en = 1'b1;  wb_fwd_rd = 0;  wb_fwd_data = 32'h33;
    @(negedge clk);
    chk("x0_a", 32'(bus.ex_opr_a), 32'h44);
    chk("x0_store", bus.ex_store_data, 32'h66);
    step(1);
    mem_fwd_en = 1'b0;
    wb_fwd_en = 1'b0;
    bus.ex_ready = 1'b1;
    step(1);

    // stall refresh on rs2
    bus.ex_ready = 1'b0;
    i = '{pc:32'h600, rs1d:1, rs2d:1, imm:0, rs1a:1, rs2a:4,
          rd:6, op:ALU_AND, asel:2, bsel:0, wr:1};
    q.push_back('{a:0, b:32'hAB, st:32'hAB, pc:32'h600,
                  rd:6, wr:1, op:ALU_AND});
    send(i);
    wb_fwd_en = 1'b1; wb_fwd_rd = 4; wb_fwd_data = 32'hAB;
    @(negedge clk);
    chk("refresh_fwd", bus.ex_store_data, 32'hAB);
    step(1);
    wb_fwd_en = 1'b0;
    @(negedge clk);
    chk("refresh_store", bus.ex_store_data, 32'hAB);
    chk("refresh_b", 32'(bus.ex_opr_b), 32'hAB);
    step(1);
    bus.ex_ready = 1'b1;
    step(1);

    // flush kills held and incoming
    bus.ex_ready = 1'b0;
    i = '{pc:32'h700, rs1d:7, rs2d:8, imm:9, rs1a:1, rs2a:2,
          rd:7, op:ALU_ADD, asel:0, bsel:1, wr:1};
    send(i);
    @(negedge clk);
    chk("flush_pre_wr", 32'(bus.ex_reg_wr), 1);
    i = '{pc:32'h800, rs1d:1, rs2d:2, imm:3, rs1a:1, rs2a:2,
          rd:8, op:ALU_SUB, asel:0, bsel:0, wr:1};
    drive(i);
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.id_ready), 0);
    step(1);
    flush = 1'b0;
    bus.id_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(bus.ex_valid), 0);
    chk("flush_wr", 32'(bus.ex_reg_wr), 0);
    chk("flush_pc", bus.ex_pc, 32'h700);
    bus.ex_ready = 1'b1;
    step(2);

    // reserved a_sel reads as zero
    i = '{pc:32'h900, rs1d:32'h77, rs2d:32'h88, imm:32'hFFFF_FFF0,
          rs1a:1, rs2a:2, rd:9, op:ALU_SLT, asel:3, bsel:1, wr:1};
    q.push_back('{a:0, b:32'hFFFF_FFF0, st:32'h88, pc:32'h900,
                  rd:9, wr:1, op:ALU_SLT});
    send(i);
    step(1);

    // async reset mid-stall
    bus.ex_ready = 1'b0;
    i = '{pc:32'hA00, rs1d:32'h5A, rs2d:32'h5B, imm:32'h5C,
          rs1a:1, rs2a:2, rd:10, op:ALU_SUB, asel:0, bsel:1, wr:1};
    send(i);
    #2;
    chk("arst_pre_valid", 32'(bus.ex_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 0);
    chk("arst_a", 32'(bus.ex_opr_a), 0);
    chk("arst_b", 32'(bus.ex_opr_b), 0);
    chk("arst_store", bus.ex_store_data, 0);
    chk("arst_pc", bus.ex_pc, 0);
    chk("arst_rd", 32'(bus.ex_rd_addr), 0);
    chk("arst_wr", 32'(bus.ex_reg_wr), 0);
    chk("arst_op", 32'(bus.ex_alu_op), 32'(ALU_ADD));
    @(negedge clk);
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    step(2);

    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
